// File: rtl/charlieplex_pkg.sv
// Shared definitions for the charlieplexed LED driver and key scanner:
// key/LED index mapping, size derivations and FSM state encodings.
package charlieplex_pkg;

  // Scan FSM states (same encoding as the LED driver)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_EVAL   = 3'd3;
  localparam logic [2:0] ST_NEXT   = 3'd4;

  // Column x driven, row y sensed -> linear key/LED index (x != y)
  function automatic int key_index(input int x, input int y, input int pc);
    if (x > y) return (pc - 1) * x + y;
    else       return (pc - 1) * x + y - 1;
  endfunction

  // Number of positions in a pc-pin charlieplexed matrix
  function automatic int keycount(input int pc);
    return pc * (pc - 1);
  endfunction

  // Index width for a pc-pin matrix (at least one bit)
  function automatic int indexbits(input int pc);
    return (pc * (pc - 1) > 1) ? $clog2(pc * (pc - 1)) : 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Parameter-width two-flop synchronizer, async active-low reset to 0.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q, s2_q;

  // Two back-to-back flops to resolve metastability on raw pad inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/charlieplex_keyscan.sv
// Charlieplexed key-matrix scanner: drives one column at a time, samples
// the rows through a synchronizer, debounces each key and reports
// press/release events over a valid/ready handshake.
// Optional: CHARLIEPLEX_KEYSCAN_DISCHARGE_EN turns the inter-column gap
// into an active discharge cycle (all pins driven low).
module charlieplex_keyscan
  import charlieplex_pkg::*;
#(
  parameter  int PINCOUNT       = 4,
  parameter  int SETTLE_CYCLES  = 4,
  parameter  int DEBOUNCE_SCANS = 3,
  localparam int KEYCOUNT       = keycount(PINCOUNT),
  localparam int INDEXBITS      = indexbits(PINCOUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [PINCOUNT-1:0]  pin_in,
  output logic [PINCOUNT-1:0]  out_en,
  output logic [PINCOUNT-1:0]  out_value,
  output logic [KEYCOUNT-1:0]  keystate,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [INDEXBITS-1:0] event_key,
  output logic                 event_pressed
);

  localparam int CB = $clog2(PINCOUNT);
  localparam int SB = $clog2(SETTLE_CYCLES);
  localparam int NB = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;

  localparam logic [CB-1:0] COL_LAST    = CB'(PINCOUNT - 1);
  localparam logic [SB-1:0] SETTLE_LAST = SB'(SETTLE_CYCLES - 1);
  localparam logic [NB-1:0] CNT_LAST    = NB'(DEBOUNCE_SCANS - 1);
  localparam logic [CB:0]   ROW_END     = (CB+1)'(PINCOUNT);

  logic [2:0]           state_q, state_d;
  logic [CB-1:0]        col_q, col_d;
  logic [CB-1:0]        row_q, row_d;
  logic [SB-1:0]        settle_q, settle_d;
  logic [PINCOUNT-1:0]  cap_q, cap_d;
  logic [KEYCOUNT-1:0]  ks_q, ks_d;
  logic [NB-1:0]        cnt_q [KEYCOUNT];
  logic [NB-1:0]        cnt_d [KEYCOUNT];
  logic                 ev_valid_q, ev_valid_d;
  logic [INDEXBITS-1:0] ev_key_q, ev_key_d;
  logic                 ev_pressed_q, ev_pressed_d;

  logic [PINCOUNT-1:0]  pin_sync;
  logic [INDEXBITS-1:0] key_k;
  logic                 samp_s, diff;
  logic [CB:0]          row_inc, row_nxt;
  logic                 row_done, can_load, stall;

  sync2 #(.W(PINCOUNT)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pin_in),
    .q_o   (pin_sync)
  );

  // Current key under evaluation and the row that follows it (skipping row==col)
  always_comb begin
    key_k    = INDEXBITS'(key_index(int'(col_q), int'(row_q), PINCOUNT));
    samp_s   = cap_q[row_q];
    diff     = samp_s ^ ks_q[key_k];
    row_inc  = {1'b0, row_q} + 1'b1;
    row_nxt  = (row_inc == {1'b0, col_q}) ? row_inc + 1'b1 : row_inc;
    row_done = (row_nxt >= ROW_END);
    can_load = !ev_valid_q || event_ready;
  end

  // Scan FSM, debounce and event generation
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    settle_d     = settle_q;
    cap_d        = cap_q;
    ks_d         = ks_q;
    cnt_d        = cnt_q;
    ev_valid_d   = ev_valid_q && !event_ready;
    ev_key_d     = ev_key_q;
    ev_pressed_d = ev_pressed_q;
    stall        = 1'b0;
    if (!enable) begin
      state_d  = ST_IDLE;
      col_d    = '0;
      settle_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_DRIVE;
          settle_d = '0;
        end
        ST_DRIVE: begin
          if (settle_q == SETTLE_LAST) state_d = ST_SAMPLE;
          else                         settle_d = settle_q + 1'b1;
        end
        ST_SAMPLE: begin
          cap_d   = pin_sync;
          row_d   = (col_q == '0) ? CB'(1) : '0;
          state_d = ST_EVAL;
        end
        ST_EVAL: begin
          if (!diff) begin
            cnt_d[key_k] = '0;
          end else if (cnt_q[key_k] < CNT_LAST) begin
            cnt_d[key_k] = cnt_q[key_k] + 1'b1;
          end else if (can_load) begin
            ks_d[key_k]  = samp_s;
            cnt_d[key_k] = '0;
            ev_key_d     = key_k;
            ev_pressed_d = samp_s;
            ev_valid_d   = 1'b1;
          end else begin
            // Consumer still holds the previous event: wait on this row
            stall = 1'b1;
          end
          if (!stall) begin
            if (row_done) state_d = ST_NEXT;
            else          row_d   = row_nxt[CB-1:0];
          end
        end
        ST_NEXT: begin
          col_d    = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
          settle_d = '0;
          state_d  = ST_DRIVE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      settle_q     <= '0;
      cap_q        <= '0;
      ks_q         <= '0;
      ev_valid_q   <= 1'b0;
      ev_key_q     <= '0;
      ev_pressed_q <= 1'b0;
      for (int i = 0; i < KEYCOUNT; i++) cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      settle_q     <= settle_d;
      cap_q        <= cap_d;
      ks_q         <= ks_d;
      ev_valid_q   <= ev_valid_d;
      ev_key_q     <= ev_key_d;
      ev_pressed_q <= ev_pressed_d;
      cnt_q        <= cnt_d;
    end
  end

  // Pad drive: selected column high while driving/sampling/evaluating
  always_comb begin
    out_en    = '0;
    out_value = '0;
    case (state_q)
      ST_DRIVE, ST_SAMPLE, ST_EVAL: begin
        out_en    = PINCOUNT'(1) << col_q;
        out_value = PINCOUNT'(1) << col_q;
      end
`ifdef CHARLIEPLEX_KEYSCAN_DISCHARGE_EN
      ST_NEXT: begin
        out_en    = '1;
        out_value = '0;
      end
`else
      ST_NEXT: begin
        out_en    = '0;
        out_value = '0;
      end
`endif
      default: begin
        out_en    = '0;
        out_value = '0;
      end
    endcase
  end

  assign keystate      = ks_q;
  assign event_valid   = ev_valid_q;
  assign event_key     = ev_key_q;
  assign event_pressed = ev_pressed_q;

endmodule
